// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Front end for a combinational 8-bit ALU. The block accepts one instruction
// at a time over a valid/ready handshake and reads its operands from a 4x8
// register file. It presents registered A/B/CNTL to the ALU, waits a
// configurable number of settle cycles, and then writes the result back. The
// op-specific subset of the ALU flags is kept in a {Z,V,N} status register.
//
// Instruction word:
//   [15:13] op   [12:11] rd   [10:9] ra   [8:7] rb   (LDI: imm = [7:0])
// Opcodes:
//   000 NOP  001 ADD  010 SUB  011 AND  100 NOT  111 LDI  (101/110 illegal)
//
// Flow: IDLE --accept--> EXEC (1+ALU_WAIT cycles) --capture--> WB --> IDLE
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int DATA_W   = 8,   // fixed at 8 to match the ALU
  parameter int ALU_WAIT = 0    // extra settle cycles in EXEC (0..15)
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction source
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  // ALU interface
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_cntl,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_zero,
  input  logic              alu_ovr,
  input  logic              alu_neg,
  // completion / status
  output logic              done,
  output logic              err,
  output logic [2:0]        status,
  // debug read port
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_WB   = 2'b10;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_BAD5 = 3'b101;
  localparam logic [2:0] OP_BAD6 = 3'b110;
  localparam logic [2:0] OP_LDI  = 3'b111;

  // Value of the EXEC cycle counter on the final (capture) EXEC cycle.
  localparam logic [3:0] WAIT_LAST = 4'(ALU_WAIT);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]        state;
  logic [3:0]        wait_cnt;

  // Fields of the accepted instruction that are still needed after accept.
  // The operands themselves live in alu_a/alu_b from the accept edge on, so
  // a write to rd == ra/rb cannot disturb an instruction already in flight.
  logic [2:0]        op_q;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] imm_q;

  logic [DATA_W-1:0] rf [4];

  // -------------------------------------------------------------------------
  // Decode of the offered instruction and of the capture cycle
  // -------------------------------------------------------------------------
  logic [2:0]        in_op;
  logic [1:0]        in_rd;
  logic [1:0]        in_ra;
  logic [1:0]        in_rb;
  logic [DATA_W-1:0] in_imm;
  logic              op_legal;
  logic              accept;
  logic              take_legal;
  logic              take_illegal;
  logic              exec_last;

  assign in_op  = in_instr[15:13];
  assign in_rd  = in_instr[12:11];
  assign in_ra  = in_instr[10:9];
  assign in_rb  = in_instr[8:7];
  assign in_imm = in_instr[DATA_W-1:0];

  assign in_ready     = (state == ST_IDLE);
  assign op_legal     = (in_op != OP_BAD5) && (in_op != OP_BAD6);
  assign accept       = in_valid && in_ready;
  assign take_legal   = accept && op_legal;
  assign take_illegal = accept && !op_legal;
  assign exec_last    = (state == ST_EXEC) && (wait_cnt == WAIT_LAST);

  // -------------------------------------------------------------------------
  // Write-back data and status update, decided from the latched opcode
  // -------------------------------------------------------------------------
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              status_we;
  logic [2:0]        status_nxt;

  // Per-op write enable, write data and flag masking for the capture edge.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred; blocking '=' is correct in
    // combinational logic, while clocked blocks below use '<=' only.
    rf_we      = 1'b0;
    rf_wdata   = alu_y;
    status_we  = 1'b0;
    status_nxt = status;

    if (exec_last) begin
      case (op_q)
        OP_ADD: begin
          rf_we      = 1'b1;
          status_we  = 1'b1;
          status_nxt = {alu_zero, alu_ovr, 1'b0};
        end
        OP_SUB: begin
          rf_we      = 1'b1;
          status_we  = 1'b1;
          status_nxt = {alu_zero, 1'b0, alu_neg};
        end
        OP_AND, OP_NOT: begin
          rf_we      = 1'b1;
          status_we  = 1'b1;
          status_nxt = {alu_zero, 2'b00};
        end
        OP_LDI: begin
          rf_we    = 1'b1;
          rf_wdata = imm_q;
        end
        default: begin
          // NOP retires without touching registers or flags.
          rf_we     = 1'b0;
          status_we = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------

  // Control FSM with the EXEC settle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_legal) begin
            state    <= ST_EXEC;
            wait_cnt <= 4'd0;
          end
        end
        ST_EXEC: begin
          if (exec_last) begin
            state <= ST_WB;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Latch the fields needed at capture when a legal instruction is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= OP_NOP;
      rd_q  <= 2'd0;
      imm_q <= '0;
    end else if (take_legal) begin
      op_q  <= in_op;
      rd_q  <= in_rd;
      imm_q <= in_imm;
    end
  end

  // Registered ALU operands and opcode; cntl is only non-zero during EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cntl <= OP_NOP;
    end else if (take_legal) begin
      alu_a    <= rf[in_ra];
      alu_b    <= rf[in_rb];
      alu_cntl <= (in_op == OP_LDI) ? OP_NOP : in_op;
    end else if (exec_last) begin
      alu_cntl <= OP_NOP;
    end
  end

  // Register file write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this storage is only four words and must read zero after reset,
      // so it is built from resettable flops; a larger array would normally
      // be left unreset and mapped to RAM.
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else if (rf_we) begin
      rf[rd_q] <= rf_wdata;
    end
  end

  // {Z,V,N} status register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status <= 3'b000;
    end else if (status_we) begin
      status <= status_nxt;
    end
  end

  // Single-cycle done/err pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= exec_last;
      err  <= take_illegal;
    end
  end

  // Debug read: combinational, shows a write from its clock edge onward.
  assign dbg_data = rf[dbg_sel];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for alu_op_sequencer.
// dut0 runs with ALU_WAIT=0 and dut1 runs with ALU_WAIT=3. Each instance
// drives its own behavioural ALU model. Expected write-back values and status
// are pushed to a scoreboard queue when an instruction is issued. They are
// popped and compared when the matching done pulse appears.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_BAD = 3'b101;

  typedef struct packed {
    logic [1:0] rd;
    logic [7:0] val;
    logic [2:0] st;
  } exp_t;

  logic clk;
  logic rst_n;

  // dut0 signals
  logic        in_valid0, in_ready0, done0, err0;
  logic [15:0] in_instr0;
  logic [7:0]  alu_a0, alu_b0, alu_y0, dbg_data0;
  logic [2:0]  alu_cntl0, status0;
  logic        alu_zero0, alu_ovr0, alu_neg0;
  logic [1:0]  dbg_sel0;

  // dut1 signals
  logic        in_valid1, in_ready1, done1, err1;
  logic [15:0] in_instr1;
  logic [7:0]  alu_a1, alu_b1, alu_y1, dbg_data1;
  logic [2:0]  alu_cntl1, status1;
  logic        alu_zero1, alu_ovr1, alu_neg1;
  logic [1:0]  dbg_sel1;

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Behavioural ALU. The subtract clamps an underflow to zero and raises neg,
  // and zero reports equality of the operands. The ovr output always carries
  // the raw a+b carry, so a sequencer that fails to mask it gets caught.
  function automatic logic [10:0] alu_model(input logic [2:0] c,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] sum;
    logic [7:0] y;
    logic       z, v, n;
    sum = {1'b0, a} + {1'b0, b};
    v   = sum[8];
    case (c)
      OP_ADD:  y = sum[7:0];
      OP_SUB:  y = (a < b) ? 8'h00 : (a - b);
      OP_AND:  y = a & b;
      OP_NOT:  y = ~a;
      default: y = 8'h00;
    endcase
    z = (c == OP_SUB) ? (a == b) : (y == 8'h00);
    n = (c == OP_SUB) ? (a < b) : y[7];
    return {y, z, v, n};
  endfunction

  assign {alu_y0, alu_zero0, alu_ovr0, alu_neg0} = alu_model(alu_cntl0, alu_a0, alu_b0);
  assign {alu_y1, alu_zero1, alu_ovr1, alu_neg1} = alu_model(alu_cntl1, alu_a1, alu_b1);

  alu_op_sequencer #(.DATA_W(8), .ALU_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_instr(in_instr0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_cntl(alu_cntl0),
    .alu_y(alu_y0), .alu_zero(alu_zero0), .alu_ovr(alu_ovr0), .alu_neg(alu_neg0),
    .done(done0), .err(err0), .status(status0),
    .dbg_sel(dbg_sel0), .dbg_data(dbg_data0)
  );

  alu_op_sequencer #(.DATA_W(8), .ALU_WAIT(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_instr(in_instr1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_cntl(alu_cntl1),
    .alu_y(alu_y1), .alu_zero(alu_zero1), .alu_ovr(alu_ovr1), .alu_neg(alu_neg1),
    .done(done1), .err(err1), .status(status1),
    .dbg_sel(dbg_sel1), .dbg_data(dbg_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 7'd0};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b111, rd, 3'b000, imm};
  endfunction

  function automatic exp_t mk(input logic [1:0] rd, input logic [7:0] val, input logic [2:0] st);
    exp_t e;
    e.rd  = rd;
    e.val = val;
    e.st  = st;
    return e;
  endfunction

  // Issue one instruction to dut0, then score it when its done pulse appears.
  task automatic run0(input string tag, input logic [15:0] ins, input exp_t e);
    int   n;
    exp_t got;
    @(negedge clk);
    n = 0;
    while (!in_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid0 = 1'b1;
    in_instr0 = ins;
    q0.push_back(e);
    @(negedge clk);
    in_valid0 = 1'b0;
    n = 0;
    while (!done0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, 16'(done0), 16'd1);
    got = q0.pop_front();
    dbg_sel0 = got.rd;
    #1;
    check({tag, " reg"}, 16'(dbg_data0), 16'(got.val));
    check({tag, " status"}, 16'(status0), 16'(got.st));
    @(negedge clk);
    check({tag, " done pulse width"}, 16'(done0), 16'd0);
  endtask

  initial begin
    exp_t        prog_exp [3];
    logic [15:0] prog [3];
    exp_t        got;
    int          idx, last_done, ndone;
    logic        pending;

    rst_n     = 1'b0;
    in_valid0 = 1'b0; in_instr0 = 16'h0000; dbg_sel0 = 2'd0;
    in_valid1 = 1'b0; in_instr1 = 16'h0000; dbg_sel1 = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst in_ready", 16'(in_ready0), 16'd1);
    check("rst done", 16'(done0), 16'd0);
    check("rst err", 16'(err0), 16'd0);
    check("rst status", 16'(status0), 16'd0);
    check("rst alu_a", 16'(alu_a0), 16'd0);
    check("rst alu_b", 16'(alu_b0), 16'd0);
    check("rst alu_cntl", 16'(alu_cntl0), 16'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel0 = 2'(i);
      #1;
      check("rst rf", 16'(dbg_data0), 16'd0);
    end

    // 1: reset during EXEC of an ADD abandons it
    @(negedge clk);
    in_valid0 = 1'b1;
    in_instr0 = enc(OP_ADD, 2'd3, 2'd0, 2'd1);
    @(negedge clk);
    in_valid0 = 1'b0;
    check("t1 cntl in exec", 16'(alu_cntl0), 16'(OP_ADD));
    check("t1 ready in exec", 16'(in_ready0), 16'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t1 no done", 16'(done0), 16'd0);
    check("t1 status", 16'(status0), 16'd0);
    check("t1 cntl", 16'(alu_cntl0), 16'd0);
    check("t1 ready", 16'(in_ready0), 16'd1);
    @(negedge clk);
    check("t1 no late done", 16'(done0), 16'd0);
    dbg_sel0 = 2'd3;
    #1;
    check("t1 R3", 16'(dbg_data0), 16'd0);

    // 2: LDI, LDI, ADD with carry
    run0("t2 ldi r1", ldi(2'd1, 8'hF0), mk(2'd1, 8'hF0, 3'b000));
    run0("t2 ldi r2", ldi(2'd2, 8'h20), mk(2'd2, 8'h20, 3'b000));
    run0("t2 add r3", enc(OP_ADD, 2'd3, 2'd1, 2'd2), mk(2'd3, 8'h10, 3'b010));
    check("t2 alu_a held", 16'(alu_a0), 16'h00F0);
    check("t2 alu_b held", 16'(alu_b0), 16'h0020);
    check("t2 cntl idle", 16'(alu_cntl0), 16'd0);

    // 3: SUB with underflow, then SUB to zero
    run0("t3 sub neg", enc(OP_SUB, 2'd0, 2'd2, 2'd1), mk(2'd0, 8'h00, 3'b001));
    run0("t3 sub zero", enc(OP_SUB, 2'd0, 2'd1, 2'd1), mk(2'd0, 8'h00, 3'b100));

    // 4: NOT, AND, NOP
    run0("t4 not r1", enc(OP_NOT, 2'd1, 2'd1, 2'd1), mk(2'd1, 8'h0F, 3'b000));
    run0("t4 and r2", enc(OP_AND, 2'd2, 2'd1, 2'd3), mk(2'd2, 8'h00, 3'b100));
    run0("t4 nop", enc(OP_NOP, 2'd3, 2'd1, 2'd1), mk(2'd3, 8'h10, 3'b100));

    // 5: illegal opcode
    @(negedge clk);
    in_valid0 = 1'b1;
    in_instr0 = enc(OP_BAD, 2'd1, 2'd0, 2'd0);
    @(negedge clk);
    in_valid0 = 1'b0;
    check("t5 err", 16'(err0), 16'd1);
    check("t5 ready", 16'(in_ready0), 16'd1);
    check("t5 status", 16'(status0), 16'b100);
    check("t5 cntl", 16'(alu_cntl0), 16'd0);
    @(negedge clk);
    check("t5 err pulse width", 16'(err0), 16'd0);
    check("t5 no done", 16'(done0), 16'd0);
    dbg_sel0 = 2'd1;
    #1;
    check("t5 R1", 16'(dbg_data0), 16'h000F);

    // 6: ALU_WAIT=3 with valid held high across three instructions
    prog[0] = ldi(2'd0, 8'h90);
    prog[1] = ldi(2'd1, 8'h80);
    prog[2] = enc(OP_ADD, 2'd2, 2'd0, 2'd1);
    prog_exp[0] = mk(2'd0, 8'h90, 3'b000);
    prog_exp[1] = mk(2'd1, 8'h80, 3'b000);
    prog_exp[2] = mk(2'd2, 8'h10, 3'b010);
    @(negedge clk);
    idx       = 0;
    last_done = -1;
    ndone     = 0;
    pending   = 1'b0;
    in_valid1 = 1'b1;
    in_instr1 = prog[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (pending) begin
        idx++;
        pending = 1'b0;
        if (idx < 3) in_instr1 = prog[idx];
        else         in_valid1 = 1'b0;
      end
      if (done1) begin
        check("t6 sb nonempty", 16'(q1.size() > 0), 16'd1);
        if (q1.size() > 0) begin
          got = q1.pop_front();
          dbg_sel1 = got.rd;
          #1;
          check("t6 reg", 16'(dbg_data1), 16'(got.val));
          check("t6 status", 16'(status1), 16'(got.st));
        end
        if (last_done >= 0) check("t6 done spacing", 16'(cyc - last_done), 16'd6);
        last_done = cyc;
        ndone++;
      end
      if (in_valid1 && in_ready1) begin
        q1.push_back(prog_exp[idx]);
        pending = 1'b1;
      end
      @(negedge clk);
    end
    check("t6 retired", 16'(ndone), 16'd3);
    check("t6 accepted", 16'(idx), 16'd3);
    check("t6 sb drained", 16'(q1.size()), 16'd0);
    check("t6 no err", 16'(err1), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
